// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR / trap unit.
// Contents: scalar types, CSR addresses, mstatus/mie/mip bit positions,
// CSR op / redirect kind / FSM state enums and the CSR op arithmetic helper.
package csr_pkg;

  typedef logic [63:0] u64;
  typedef logic        u1;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  // MTIP in mip and MTIE in mie share this position.
  localparam int MIX_MTI        = 7;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_t;

  typedef enum logic [1:0] {
    RK_NONE = 2'b00,
    RK_CSR  = 2'b01,
    RK_MRET = 2'b10,
    RK_TRAP = 2'b11
  } redirect_kind_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } fsm_state_t;

  // Value a CSR instruction would leave in the target register.
  function automatic u64 csr_apply(input csr_op_t op, input u64 old_val, input u64 operand);
    u64 res;
    case (op)
      CSR_RW:  res = operand;
      CSR_RS:  res = old_val | operand;
      CSR_RC:  res = old_val & ~operand;
      default: res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_trap_unit_regfile.sv
// csr_regfile: machine-mode CSR storage, read muxes and update arithmetic.
// Ports:
//   clk, resetn              clock, async active-low reset
//   mtip                     timer interrupt level mirrored into mip.MTIP
//   trap_en/pc/cause/tval    trap entry (exception or interrupt) this edge
//   mret_en                  mret retires this edge
//   csr_we/op/addr/wdata     CSR read-modify-write this edge
//   raddr / rdata            combinational read port (pre-update value)
//   mtvec_base               trap target, low bits already zero
//   mepc_val                 current mepc, mret target
//   irq_pending              mstatus.MIE & mie.MTIE & mtip
// The *_en / csr_we inputs are mutually exclusive; the top decodes priority.
module csr_regfile
  import csr_pkg::*;
#(
  parameter u64 MCYCLE_INC = 64'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mtip,
  input  logic        trap_en,
  input  logic [63:0] trap_pc,
  input  logic [63:0] trap_cause,
  input  logic [63:0] trap_tval,
  input  logic        mret_en,
  input  logic        csr_we,
  input  csr_op_t     csr_op,
  input  logic [11:0] csr_addr,
  input  logic [63:0] csr_wdata,
  input  logic [11:0] raddr,
  output logic [63:0] rdata,
  output logic [63:0] mtvec_base,
  output logic [63:0] mepc_val,
  output logic        irq_pending
);

  u64 mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mcycle;
  u64 mip_val;
  u64 cur_val;
  u64 wr_val;

  // mip has no storage: only MTIP is live, and it follows the input level.
  assign mip_val = {56'd0, mtip, 7'd0};

  function automatic u64 csr_read(input logic [11:0] addr);
    u64 v;
    case (addr)
      CSR_MSTATUS:  v = mstatus;
      CSR_MIE:      v = mie;
      CSR_MTVEC:    v = mtvec;
      CSR_MSCRATCH: v = mscratch;
      CSR_MEPC:     v = mepc;
      CSR_MCAUSE:   v = mcause;
      CSR_MTVAL:    v = mtval;
      CSR_MIP:      v = mip_val;
      CSR_MCYCLE:   v = mcycle;
      default:      v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    rdata   = csr_read(raddr);
    cur_val = csr_read(csr_addr);
    wr_val  = csr_apply(csr_op, cur_val, csr_wdata);
  end

  assign mtvec_base  = {mtvec[63:2], 2'b00};
  assign mepc_val    = mepc;
  assign irq_pending = mstatus[MSTATUS_MIE] & mie[MIX_MTI] & mtip;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mstatus  <= '0;
      mie      <= '0;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
      mcycle   <= '0;
    end else begin
      // Free-running; a CSR write below overrides this for the same edge.
      mcycle <= mcycle + MCYCLE_INC;
      if (trap_en) begin
        mepc                                   <= trap_pc;
        mcause                                 <= trap_cause;
        mtval                                  <= trap_tval;
        mstatus[MSTATUS_MPIE]                  <= mstatus[MSTATUS_MIE];
        mstatus[MSTATUS_MIE]                   <= 1'b0;
        mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
      end else if (mret_en) begin
        mstatus[MSTATUS_MIE]                   <= mstatus[MSTATUS_MPIE];
        mstatus[MSTATUS_MPIE]                  <= 1'b1;
        mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b00;
      end else if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS:  mstatus  <= wr_val;
          CSR_MIE:      mie      <= wr_val;
          CSR_MTVEC:    mtvec    <= {wr_val[63:2], 2'b00};
          CSR_MSCRATCH: mscratch <= wr_val;
          CSR_MEPC:     mepc     <= {wr_val[63:2], 2'b00};
          CSR_MCAUSE:   mcause   <= wr_val;
          CSR_MTVAL:    mtval    <= wr_val;
          CSR_MCYCLE:   mcycle   <= wr_val;
          default:      ;  // mip and unimplemented addresses: write dropped
        endcase
      end
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: writeback-stage machine-mode CSR file and trap controller.
// Retires CSR ops, exceptions and mret and raises one redirect request for
// the fetch-stage next-PC selector (trap->mtvec, mret->mepc, CSR op->pc+4).
// Optional feature macro: CSR_TIMER_INTR_EN adds the timer_irq input and
// machine timer interrupts taken in place of the retiring instruction.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   wb_*                        retiring instruction (valid, pc, csr op, exc, mret)
//   csr_raddr / csr_rdata       combinational CSR read (pre-update, 0 if unimplemented)
//   redirect_valid/kind/pc      redirect request to fetch
//   redirect_ready              fetch accepts the redirect
//   wb_stall                    hold writeback, equal to redirect_valid
//   timer_irq                   (CSR_TIMER_INTR_EN only) machine timer interrupt level
//   dbg_state                   FSM state for observation
//
// Redirect handshake: redirect_valid is raised one cycle after the retiring
// edge with kind/pc held stable; the request transfers on a clock edge where
// redirect_valid and redirect_ready are both 1, and redirect_valid is low from
// the following cycle. While valid is high writeback is stalled and wb_* ignored.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter u64 MCYCLE_INC = 64'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [63:0] wb_pc,
  input  logic [1:0]  wb_csr_op,
  input  logic [11:0] wb_csr_addr,
  input  logic [63:0] wb_csr_wdata,
  input  logic        wb_exc_valid,
  input  logic [3:0]  wb_exc_code,
  input  logic [63:0] wb_exc_tval,
  input  logic        wb_mret,
  input  logic [11:0] csr_raddr,
  output logic [63:0] csr_rdata,
  output logic        redirect_valid,
  output logic [1:0]  redirect_kind,
  output logic [63:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        wb_stall,
`ifdef CSR_TIMER_INTR_EN
  input  logic        timer_irq,
`endif
  output fsm_state_t  dbg_state
);

  fsm_state_t     state;
  redirect_kind_t kind_q;
  csr_op_t        op;
  logic           mtip;
  logic           irq_pending;
  logic           take, do_irq, do_exc, do_mret, do_csr;
  logic           trap_en, csr_we;
  u64             trap_cause, trap_tval;
  u64             mtvec_base, mepc_val;

`ifdef CSR_TIMER_INTR_EN
  assign mtip = timer_irq;
`else
  assign mtip = 1'b0;
`endif

  assign op = csr_op_t'(wb_csr_op);

  // Exactly one action per retiring instruction: irq > exc > mret > csr op.
  always_comb begin
    take       = (state == ST_IDLE) && wb_valid;
    do_irq     = take && irq_pending;
    do_exc     = take && !irq_pending && wb_exc_valid;
    do_mret    = take && !irq_pending && !wb_exc_valid && wb_mret;
    do_csr     = take && !irq_pending && !wb_exc_valid && !wb_mret && (op != CSR_NONE);
    // RS/RC with a zero operand still redirects but performs no write, so it
    // does not disturb the mcycle increment.
    csr_we     = do_csr && ((op == CSR_RW) || (wb_csr_wdata != 64'd0));
    trap_en    = do_irq || do_exc;
    trap_cause = do_irq ? {1'b1, 63'd7} : {60'd0, wb_exc_code};
    trap_tval  = do_irq ? 64'd0 : wb_exc_tval;
  end

  csr_regfile #(
    .MCYCLE_INC (MCYCLE_INC)
  ) u_regfile (
    .clk         (clk),
    .resetn      (resetn),
    .mtip        (mtip),
    .trap_en     (trap_en),
    .trap_pc     (wb_pc),
    .trap_cause  (trap_cause),
    .trap_tval   (trap_tval),
    .mret_en     (do_mret),
    .csr_we      (csr_we),
    .csr_op      (op),
    .csr_addr    (wb_csr_addr),
    .csr_wdata   (wb_csr_wdata),
    .raddr       (csr_raddr),
    .rdata       (csr_rdata),
    .mtvec_base  (mtvec_base),
    .mepc_val    (mepc_val),
    .irq_pending (irq_pending)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      redirect_valid <= 1'b0;
      kind_q         <= RK_NONE;
      redirect_pc    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trap_en) begin
            state          <= ST_REDIR;
            redirect_valid <= 1'b1;
            kind_q         <= RK_TRAP;
            redirect_pc    <= mtvec_base;
          end else if (do_mret) begin
            state          <= ST_REDIR;
            redirect_valid <= 1'b1;
            kind_q         <= RK_MRET;
            redirect_pc    <= mepc_val;
          end else if (do_csr) begin
            state          <= ST_REDIR;
            redirect_valid <= 1'b1;
            kind_q         <= RK_CSR;
            redirect_pc    <= wb_pc + 64'd4;
          end
        end
        ST_REDIR: begin
          if (redirect_ready) begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
          end
        end
        default: begin
          state          <= ST_IDLE;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

  assign redirect_kind = kind_q;
  assign wb_stall      = redirect_valid;
  assign dbg_state     = state;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed, table-driven bench for csr_trap_unit plus hand sequences for
// stalls, mcycle write precedence, timer interrupt (when built with
// CSR_TIMER_INTR_EN) and reset in the middle of a redirect.
module tb_csr_trap_unit;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wb_valid = 1'b0;
  logic [63:0] wb_pc = '0;
  logic [1:0]  wb_csr_op = '0;
  logic [11:0] wb_csr_addr = '0;
  logic [63:0] wb_csr_wdata = '0;
  logic        wb_exc_valid = 1'b0;
  logic [3:0]  wb_exc_code = '0;
  logic [63:0] wb_exc_tval = '0;
  logic        wb_mret = 1'b0;
  logic [11:0] csr_raddr = '0;
  logic [63:0] csr_rdata;
  logic        redirect_valid;
  logic [1:0]  redirect_kind;
  logic [63:0] redirect_pc;
  logic        redirect_ready = 1'b0;
  logic        wb_stall;
  logic        timer_irq = 1'b0;
  fsm_state_t  dbg_state;

  csr_trap_unit dut (
    .clk            (clk),
    .resetn         (resetn),
    .wb_valid       (wb_valid),
    .wb_pc          (wb_pc),
    .wb_csr_op      (wb_csr_op),
    .wb_csr_addr    (wb_csr_addr),
    .wb_csr_wdata   (wb_csr_wdata),
    .wb_exc_valid   (wb_exc_valid),
    .wb_exc_code    (wb_exc_code),
    .wb_exc_tval    (wb_exc_tval),
    .wb_mret        (wb_mret),
    .csr_raddr      (csr_raddr),
    .csr_rdata      (csr_rdata),
    .redirect_valid (redirect_valid),
    .redirect_kind  (redirect_kind),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .wb_stall       (wb_stall),
`ifdef CSR_TIMER_INTR_EN
    .timer_irq      (timer_irq),
`endif
    .dbg_state      (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic        exc;
    logic [3:0]  code;
    logic [63:0] tval;
    logic        mret;
    logic [1:0]  kind;
    logic [63:0] rpc;
    logic [11:0] a_addr;
    logic [63:0] a_val;
    logic [11:0] b_addr;
    logic [63:0] b_val;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic rd_check(input string name, input logic [11:0] addr, input logic [63:0] exp);
    csr_raddr = addr;
    #1;
    check(name, csr_rdata, exp);
  endtask

  function automatic vec_t mk(
    input logic [63:0] pc, input logic [1:0] op, input logic [11:0] addr,
    input logic [63:0] wdata, input logic exc, input logic [3:0] code,
    input logic [63:0] tval, input logic mret, input logic [1:0] kind,
    input logic [63:0] rpc, input logic [11:0] a_addr, input logic [63:0] a_val,
    input logic [11:0] b_addr, input logic [63:0] b_val);
    vec_t v;
    v.pc = pc; v.op = op; v.addr = addr; v.wdata = wdata; v.exc = exc;
    v.code = code; v.tval = tval; v.mret = mret; v.kind = kind; v.rpc = rpc;
    v.a_addr = a_addr; v.a_val = a_val; v.b_addr = b_addr; v.b_val = b_val;
    return v;
  endfunction

  // Driver: present one retiring instruction for one edge.
  task automatic drive_wb(input vec_t v);
    @(negedge clk);
    wb_valid     = 1'b1;
    wb_pc        = v.pc;
    wb_csr_op    = v.op;
    wb_csr_addr  = v.addr;
    wb_csr_wdata = v.wdata;
    wb_exc_valid = v.exc;
    wb_exc_code  = v.code;
    wb_exc_tval  = v.tval;
    wb_mret      = v.mret;
    @(posedge clk);
    #1;
    wb_valid     = 1'b0;
    wb_csr_op    = 2'b00;
    wb_exc_valid = 1'b0;
    wb_mret      = 1'b0;
  endtask

  // Retire, expect a one-cycle redirect with ready high, then check two CSRs.
  task automatic apply_vec(input vec_t v, input string tag);
    drive_wb(v);
    @(negedge clk);
    check({tag, "_valid"}, {63'd0, redirect_valid}, 64'd1);
    check({tag, "_kind"}, {62'd0, redirect_kind}, {62'd0, v.kind});
    check({tag, "_pc"}, redirect_pc, v.rpc);
    check({tag, "_stall"}, {63'd0, wb_stall}, 64'd1);
    redirect_ready = 1'b1;
    @(posedge clk);
    #1;
    redirect_ready = 1'b0;
    @(negedge clk);
    check({tag, "_drop"}, {63'd0, redirect_valid}, 64'd0);
    rd_check({tag, "_csr_a"}, v.a_addr, v.a_val);
    rd_check({tag, "_csr_b"}, v.b_addr, v.b_val);
  endtask

  initial begin
    vecs[0]  = mk(64'h100, 2'b01, 12'h305, 64'h8000_0103, 0, 4'd0, 64'h0, 0, 2'b01, 64'h104,
                  12'h305, 64'h8000_0100, 12'h340, 64'h0);
    vecs[1]  = mk(64'h104, 2'b10, 12'h300, 64'h8, 0, 4'd0, 64'h0, 0, 2'b01, 64'h108,
                  12'h300, 64'h8, 12'h305, 64'h8000_0100);
    vecs[2]  = mk(64'h200, 2'b00, 12'h000, 64'h0, 1, 4'd2, 64'hdead, 0, 2'b11, 64'h8000_0100,
                  12'h341, 64'h200, 12'h300, 64'h1880);
    vecs[3]  = mk(64'h300, 2'b01, 12'h340, 64'h1234_5678, 0, 4'd0, 64'h0, 0, 2'b01, 64'h304,
                  12'h340, 64'h1234_5678, 12'h342, 64'h2);
    vecs[4]  = mk(64'h400, 2'b01, 12'h340, 64'hffff, 1, 4'd5, 64'h0, 0, 2'b11, 64'h8000_0100,
                  12'h340, 64'h1234_5678, 12'h300, 64'h1800);
    vecs[5]  = mk(64'h500, 2'b10, 12'h340, 64'h0, 0, 4'd0, 64'h0, 0, 2'b01, 64'h504,
                  12'h340, 64'h1234_5678, 12'h342, 64'h5);
    vecs[6]  = mk(64'h600, 2'b11, 12'h340, 64'h78, 0, 4'd0, 64'h0, 0, 2'b01, 64'h604,
                  12'h340, 64'h1234_5600, 12'h341, 64'h400);
    vecs[7]  = mk(64'h700, 2'b01, 12'h341, 64'h1003, 0, 4'd0, 64'h0, 0, 2'b01, 64'h704,
                  12'h341, 64'h1000, 12'h343, 64'h0);
    vecs[8]  = mk(64'hFFFF_FFFF_FFFF_FFFC, 2'b01, 12'h7C0, 64'h5, 0, 4'd0, 64'h0, 0, 2'b01, 64'h0,
                  12'h7C0, 64'h0, 12'h341, 64'h1000);
    vecs[9]  = mk(64'h800, 2'b01, 12'h300, 64'h80, 0, 4'd0, 64'h0, 0, 2'b01, 64'h804,
                  12'h300, 64'h80, 12'h340, 64'h1234_5600);
    vecs[10] = mk(64'h900, 2'b00, 12'h000, 64'h0, 0, 4'd0, 64'h0, 1, 2'b10, 64'h1000,
                  12'h300, 64'h88, 12'h341, 64'h1000);
    vecs[11] = mk(64'hA00, 2'b01, 12'h340, 64'h0, 0, 4'd0, 64'h0, 1, 2'b10, 64'h1000,
                  12'h340, 64'h1234_5600, 12'h300, 64'h88);
    vecs[12] = mk(64'hB00, 2'b01, 12'h304, 64'h80, 0, 4'd0, 64'h0, 0, 2'b01, 64'hB04,
                  12'h304, 64'h80, 12'h344, 64'h0);

    // Reset state
    #2;
    check("rst_valid", {63'd0, redirect_valid}, 64'd0);
    check("rst_kind", {62'd0, redirect_kind}, 64'd0);
    check("rst_pc", redirect_pc, 64'd0);
    check("rst_stall", {63'd0, wb_stall}, 64'd0);
    rd_check("rst_mtvec", 12'h305, 64'd0);
    rd_check("rst_mcycle", 12'hB00, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NVEC; i++) apply_vec(vecs[i], $sformatf("v%0d", i));

    // mret held by fetch for three cycles; new writeback input is ignored.
    apply_vec(mk(64'hC00, 2'b01, 12'h341, 64'h200, 0, 4'd0, 64'h0, 0, 2'b01, 64'hC04,
                 12'h341, 64'h200, 12'h300, 64'h88), "hold_setup");
    drive_wb(mk(64'hD00, 2'b00, 12'h000, 64'h0, 0, 4'd0, 64'h0, 1, 2'b00, 64'h0,
                12'h000, 64'h0, 12'h000, 64'h0));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d_valid", c), {63'd0, redirect_valid}, 64'd1);
      check($sformatf("hold%0d_kind", c), {62'd0, redirect_kind}, 64'd2);
      check($sformatf("hold%0d_pc", c), redirect_pc, 64'h200);
      check($sformatf("hold%0d_stall", c), {63'd0, wb_stall}, 64'd1);
      check($sformatf("hold%0d_state", c), {63'd0, dbg_state}, {63'd0, ST_REDIR});
      if (c == 1) begin
        wb_valid = 1'b1; wb_csr_op = 2'b01; wb_csr_addr = 12'h340; wb_csr_wdata = 64'hbad;
      end
      if (c == 2) begin
        wb_valid = 1'b0; wb_csr_op = 2'b00;
      end
      if (c == 3) redirect_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    redirect_ready = 1'b0;
    @(negedge clk);
    check("hold_drop", {63'd0, redirect_valid}, 64'd0);
    rd_check("hold_mscratch", 12'h340, 64'h1234_5600);
    rd_check("hold_mstatus", 12'h300, 64'h88);

    // mcycle write wins over the increment, then keeps counting while stalled.
    drive_wb(mk(64'hE00, 2'b01, 12'hB00, 64'd100, 0, 4'd0, 64'h0, 0, 2'b01, 64'hE04,
                12'h000, 64'h0, 12'h000, 64'h0));
    @(negedge clk);
    check("mcyc_redirect_pc", redirect_pc, 64'hE04);
    rd_check("mcyc_write", 12'hB00, 64'd100);
    @(negedge clk);
    rd_check("mcyc_inc", 12'hB00, 64'd101);
    redirect_ready = 1'b1;
    @(posedge clk);
    #1;
    redirect_ready = 1'b0;
    @(negedge clk);
    check("mcyc_drop", {63'd0, redirect_valid}, 64'd0);

`ifdef CSR_TIMER_INTR_EN
    // Timer interrupt beats a simultaneous exception.
    timer_irq = 1'b1;
    #1;
    rd_check("irq_mip", 12'h344, 64'h80);
    apply_vec(mk(64'h300, 2'b00, 12'h000, 64'h0, 1, 4'd2, 64'h0, 0, 2'b11, 64'h8000_0100,
                 12'h342, 64'h8000_0000_0000_0007, 12'h341, 64'h300), "irq");
    timer_irq = 1'b0;
`endif

    // Reset in the middle of a redirect.
    drive_wb(mk(64'hF00, 2'b01, 12'h340, 64'h55, 0, 4'd0, 64'h0, 0, 2'b01, 64'hF04,
                12'h000, 64'h0, 12'h000, 64'h0));
    @(negedge clk);
    check("mid_valid", {63'd0, redirect_valid}, 64'd1);
    #1;
    resetn = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, redirect_valid}, 64'd0);
    check("mid_rst_kind", {62'd0, redirect_kind}, 64'd0);
    check("mid_rst_stall", {63'd0, wb_stall}, 64'd0);
    check("mid_rst_state", {63'd0, dbg_state}, {63'd0, ST_IDLE});
    @(negedge clk);
    resetn = 1'b1;
    rd_check("post_mtvec", 12'h305, 64'd0);
    rd_check("post_mscratch", 12'h340, 64'd0);
    rd_check("post_mstatus", 12'h300, 64'd0);
    rd_check("post_mcycle0", 12'hB00, 64'd0);
    @(negedge clk);
    rd_check("post_mcycle1", 12'hB00, 64'd1);
    repeat (3) @(negedge clk);
    rd_check("post_mcycle4", 12'hB00, 64'd4);
    check("post_valid", {63'd0, redirect_valid}, 64'd0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
